pipeline_ctrl: RTL

- Hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards that EX-stage forwarding cannot cover and stalls IF/ID while inserting an EX bubble.
- Flushes wrong-path instructions after a taken jump or branch resolved in EX.
- Freezes the whole pipeline while data memory is busy. Mealy controller: state registered, control outputs combinational.

---
 rtl/pipeline_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stall, branch flush, memory freeze.
// Optional stall/flush performance counters are enabled with PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] Rs1_id,
    input  logic [4:0] Rs2_id,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic [4:0] Rd_ex,
    input  logic       enable_reg_ex,
    input  logic       read_word_ex,
    input  logic       load_new_PC_ex,
    input  logic       mem_busy,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       bubble_ex,
    output logic       flush_if_id,
    output logic       flush_id_ex,
    output logic [1:0] state_o
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lu;
    logic          sif_c, sid_c, sex_c, bub_c, fif_c, fie_c;

    assign lu = read_word_ex & enable_reg_ex & (Rd_ex != 5'd0) &
                ((uses_rs1 & (Rs1_id == Rd_ex)) | (uses_rs2 & (Rs2_id == Rd_ex)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sif_c   = 1'b0;
        sid_c   = 1'b0;
        sex_c   = 1'b0;
        bub_c   = 1'b0;
        fif_c   = 1'b0;
        fie_c   = 1'b0;
        if (mem_busy) begin
            sif_c   = 1'b1;
            sid_c   = 1'b1;
            sex_c   = 1'b1;
            state_d = MEM_WAIT;
        end else if (state_q == FLUSH) begin
            // EX holds a NOP here, so jumps and load-use are both don't-care.
            fif_c = 1'b1;
            if (cnt_q <= CW'(1)) begin
                cnt_d   = '0;
                state_d = RUN;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else begin
            state_d = RUN;
            if (load_new_PC_ex) begin
                fif_c = 1'b1;
                fie_c = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    cnt_d   = CW'(FLUSH_CYCLES - 1);
                    state_d = FLUSH;
                end
            end else begin
                if (lu) begin
                    sif_c   = 1'b1;
                    sid_c   = 1'b1;
                    bub_c   = 1'b1;
                    state_d = LOAD_STALL;
                end
                // A flush interrupted by mem_busy resumes once memory releases.
                if (cnt_q != '0) state_d = FLUSH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_if    = reset_n & sif_c;
    assign stall_id    = reset_n & sid_c;
    assign stall_ex    = reset_n & sex_c;
    assign bubble_ex   = reset_n & bub_c;
    assign flush_if_id = reset_n & fif_c;
    assign flush_id_ex = reset_n & fie_c;
    assign state_o     = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_cycles_q, flush_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cycles_d = flush_cycles_q;
        if (stall_if && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
        if (flush_if_id && (flush_cycles_q != 32'hFFFF_FFFF)) flush_cycles_d = flush_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule
